// File: rtl/entrada_saida_sequencial.sv
// Sequential I/O port for a simple CPU.
//  - Input op: waits for a confirm push-button edge, then latches the switches.
//  - Output op: converts a 32-bit value to decimal (iterative double-dabble,
//    one bit per cycle) and drives active-low 7-segment digits.
// Optional build macro: ENTRADA_SAIDA_DEBOUNCE_EN adds a counter-based debouncer
// on the synchronised confirm signal.
module entrada_saida_sequencial #(
    parameter int SW_WIDTH        = 10,
    parameter int N_DIGITS        = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [SW_WIDTH-1:0]   switch_dado,
    input  logic                  confirm,
    input  logic [31:0]           entrada_dado,
    input  logic                  IOE,
    input  logic                  IOsel,
    output logic [31:0]           saida_dado,
    output logic                  aguardando,
    output logic                  busy,
    output logic [7*N_DIGITS-1:0] hex_out
);

    // Digit 0 shows "0" (7'h40), every other digit blank (7'h7F).
    localparam logic [7*N_DIGITS-1:0] HEX_RST = ~((7*N_DIGITS)'(7'h3F));

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'h40;
            4'd1: seg7 = 7'h79;
            4'd2: seg7 = 7'h24;
            4'd3: seg7 = 7'h30;
            4'd4: seg7 = 7'h19;
            4'd5: seg7 = 7'h12;
            4'd6: seg7 = 7'h02;
            4'd7: seg7 = 7'h78;
            4'd8: seg7 = 7'h00;
            4'd9: seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    logic sync1, sync2;
    logic conf_lvl, conf_prev, conf_evt;

    // Two-flop synchroniser for the asynchronous push-button.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= confirm;
            sync2 <= sync1;
        end
    end

`ifdef ENTRADA_SAIDA_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [CW-1:0] deb_cnt;

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            conf_lvl <= 1'b0;
            deb_cnt  <= '0;
        end else if (sync2 == conf_lvl) begin
            deb_cnt  <= '0;
        end else if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            conf_lvl <= sync2;
            deb_cnt  <= '0;
        end else begin
            deb_cnt  <= deb_cnt + 1'b1;
        end
    end
`else
    assign conf_lvl = sync2;
`endif

    // Remember previous level so a press yields a single-cycle event.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) conf_prev <= 1'b0;
        else          conf_prev <= conf_lvl;
    end

    assign conf_evt = conf_lvl & ~conf_prev;

    // Input op: arm on request, load switches on first confirm, cancel when IOE drops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            aguardando <= 1'b0;
            saida_dado <= '0;
        end else if (aguardando) begin
            if (!IOE) begin
                aguardando <= 1'b0;
            end else if (conf_evt) begin
                saida_dado <= 32'(switch_dado);
                aguardando <= 1'b0;
            end
        end else if (IOE && IOsel) begin
            aguardando <= 1'b1;
        end
    end

    logic [31:0]          valor;
    logic [39:0]          bcd, bcd_adj, bcd_nx;
    logic [4:0]           bit_cnt;
    logic [7*N_DIGITS-1:0] seg_nx;
    logic                 lead;
    logic [3:0]           dig;

    // One double-dabble step: add 3 to digits >= 5, then shift in the next MSB.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_nx = {bcd_adj[38:0], valor[31]};
    end

    // Segment encoding of the step result with leading-zero blanking.
    always_comb begin
        seg_nx = '1;
        lead   = 1'b1;
        dig    = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            dig = bcd_nx[4*k +: 4];
            if (lead && dig == 4'd0 && k != 0) begin
                seg_nx[7*k +: 7] = 7'h7F;
            end else begin
                seg_nx[7*k +: 7] = seg7(dig);
                lead = 1'b0;
            end
        end
    end

    // Output op: capture (or restart), run 32 steps, publish display on the last one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valor   <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            hex_out <= HEX_RST;
        end else if (IOE && !IOsel) begin
            valor   <= entrada_dado;
            bcd     <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            valor <= {valor[30:0], 1'b0};
            bcd   <= bcd_nx;
            if (bit_cnt == 5'd31) begin
                busy    <= 1'b0;
                hex_out <= seg_nx;
            end else begin
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_entrada_saida_sequencial.sv
// Randomised scoreboard bench for entrada_saida_sequencial (default build).
module tb_entrada_saida_sequencial;
    localparam int SW = 10;
    localparam int ND = 8;
    localparam logic [7*ND-1:0] HEX_RST = {{(ND-1){7'h7F}}, 7'h40};

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [SW-1:0]     switch_dado = '0;
    logic              confirm = 1'b0;
    logic [31:0]       entrada_dado = '0;
    logic              IOE = 1'b0;
    logic              IOsel = 1'b0;
    logic [31:0]       saida_dado;
    logic              aguardando;
    logic              busy;
    logic [7*ND-1:0]   hex_out;

    entrada_saida_sequencial #(.SW_WIDTH(SW), .N_DIGITS(ND), .DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .reset_n(reset_n), .switch_dado(switch_dado), .confirm(confirm),
        .entrada_dado(entrada_dado), .IOE(IOE), .IOsel(IOsel), .saida_dado(saida_dado),
        .aguardando(aguardando), .busy(busy), .hex_out(hex_out)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    logic [31:0]     exp_saida_q[$];
    logic [7*ND-1:0] exp_hex_q[$];
    logic [31:0]     model_saida = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference display: value mod 10^ND in decimal, leading zeros blank.
    function automatic logic [7*ND-1:0] exp_hex(input logic [31:0] v);
        logic [6:0] seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        longint unsigned m = 64'(v);
        longint unsigned md = 1;
        logic [7*ND-1:0] r = '1;
        int k = 0;
        repeat (ND) md = md * 10;
        m = m % md;
        do begin
            r[7*k +: 7] = seg[m % 10];
            m = m / 10;
            k++;
        end while (m != 0 && k < ND);
        return r;
    endfunction

    // Monitor: checks display on every busy fall and saida_dado on every aguardando fall.
    logic            prev_busy = 1'b0, prev_ag = 1'b0;
    int              bcnt = 0;
    logic [7*ND-1:0] last_hex = HEX_RST;
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_busy = 1'b0;
            prev_ag   = 1'b0;
            bcnt      = 0;
            last_hex  = HEX_RST;
        end else begin
            if (busy) begin
                bcnt++;
                if (prev_busy) chk("hex_hold", 64'(hex_out), 64'(last_hex));
            end
            if (prev_busy && !busy) begin
                chk("busy_len", 64'(bcnt), 64'd32);
                if (exp_hex_q.size() == 0) begin
                    chk("hex_unexpected", 64'(hex_out), 64'(last_hex));
                end else begin
                    last_hex = exp_hex_q.pop_front();
                    chk("hex", 64'(hex_out), 64'(last_hex));
                end
            end
            if (prev_ag && !aguardando) begin
                if (exp_saida_q.size() == 0) chk("saida_unexpected", 64'(aguardando), 64'd1);
                else chk("saida", 64'(saida_dado), 64'(exp_saida_q.pop_front()));
            end
            if (IOE && !IOsel) bcnt = 0;
            prev_busy = busy;
            prev_ag   = aguardando;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic write_val(input logic [31:0] v, input bit completes);
        IOE = 1'b1; IOsel = 1'b0; entrada_dado = v;
        if (completes) exp_hex_q.push_back(exp_hex(v));
        cyc(1);
        IOE = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            cyc(1);
            n++;
        end
        cyc(2);
        chk("busy_timeout", 64'(busy), 64'd0);
    endtask

    task automatic in_op(input logic [SW-1:0] sw);
        switch_dado = sw; IOE = 1'b1; IOsel = 1'b1;
        exp_saida_q.push_back(32'(sw));
        model_saida = 32'(sw);
        cyc(2);
        confirm = 1'b1;
        cyc(2);
        chk("ag_hold", 64'(aguardando), 64'd1);
        cyc(1);
        chk("ag_fall", 64'(aguardando), 64'd0);
        chk("saida_load", 64'(saida_dado), 64'(model_saida));
        IOE = 1'b0;
        cyc(1);
        confirm = 1'b0;
        cyc(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dir_vals [6] = '{32'hFFFF_FFFF, 32'd0, 32'd99999999, 32'd100000000, 32'd5, 32'd1000};
        logic [31:0] a, b, c;

        // Reset state, during and after reset.
        cyc(3);
        chk("rst_saida", 64'(saida_dado), 64'd0);
        chk("rst_ag", 64'(aguardando), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hex", 64'(hex_out), 64'(HEX_RST));
        reset_n = 1'b1;
        cyc(2);
        chk("post_rst_hex", 64'(hex_out), 64'(HEX_RST));
        chk("post_rst_saida", 64'(saida_dado), 64'd0);

        // Known example.
        write_val(32'd1234, 1'b1);
        wait_idle();
        chk("hex_1234", 64'(hex_out), 64'({{4{7'h7F}}, 7'h79, 7'h24, 7'h30, 7'h19}));
        write_val(32'hFFFF_FFFF, 1'b1);
        wait_idle();
        chk("hex_ffffffff", 64'(hex_out),
            64'({7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12}));

        foreach (dir_vals[i]) begin
            write_val(dir_vals[i], 1'b1);
            wait_idle();
        end
        for (int i = 0; i < 10; i++) begin
            write_val((i % 2) ? $urandom : $urandom_range(0, 9999), 1'b1);
            wait_idle();
        end

        // Restart mid-conversion: 99 must never reach the display.
        write_val(32'd99, 1'b0);
        cyc(9);
        write_val(32'd7, 1'b1);
        wait_idle();

        // IOE held for three cycles: only the last value completes.
        a = $urandom; b = $urandom; c = $urandom;
        IOE = 1'b1; IOsel = 1'b0; entrada_dado = a; cyc(1);
        entrada_dado = b; cyc(1);
        entrada_dado = c; exp_hex_q.push_back(exp_hex(c)); cyc(1);
        IOE = 1'b0;
        wait_idle();

        // Input ops.
        in_op(10'h2A5);
        for (int i = 0; i < 6; i++) in_op(SW'($urandom));

        // Cancel a pending input by dropping IOE: saida_dado holds.
        switch_dado = ~switch_dado;
        exp_saida_q.push_back(model_saida);
        IOE = 1'b1; IOsel = 1'b1; cyc(1);
        chk("ag_set", 64'(aguardando), 64'd1);
        IOE = 1'b0; cyc(2);
        chk("ag_cancel", 64'(aguardando), 64'd0);

        // Confirm while idle is ignored.
        confirm = 1'b1; cyc(4);
        confirm = 1'b0; cyc(4);
        chk("confirm_idle", 64'(saida_dado), 64'(model_saida));

        // Reset mid-conversion: no partial result.
        write_val(32'd12345678, 1'b0);
        cyc(5);
        reset_n = 1'b0;
        cyc(2);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hex", 64'(hex_out), 64'(HEX_RST));
        chk("rst_mid_saida", 64'(saida_dado), 64'd0);
        reset_n = 1'b1;
        model_saida = '0;
        cyc(40);
        chk("rst_mid_hex_after", 64'(hex_out), 64'(HEX_RST));

        // Reset mid-wait.
        IOE = 1'b1; IOsel = 1'b1; cyc(2);
        reset_n = 1'b0; IOE = 1'b0;
        cyc(2);
        chk("rst_wait_ag", 64'(aguardando), 64'd0);
        reset_n = 1'b1;
        cyc(2);

        // Post-reset conversion still works.
        write_val(32'd42, 1'b1);
        wait_idle();
        chk("queues_drained", 64'(exp_hex_q.size() + exp_saida_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
